ofifo_align: RTL

Output-side column aligner for the systolic array. Each of `col` array columns pushes results into its own lane whenever its column fires, so lanes fill at different times. `ofifo_align` buffers each lane independently. It presents one aligned output row only when every lane holds data, then pops all lanes together on `rd`. It is the collecting end of the array datapath, mirroring the row-parallel input FIFO that feeds the array.

---
 rtl/ofifo_pkg.sv | 13 +
 rtl/ofifo_lane.sv | 77 +++++++
 rtl/ofifo_align.sv | 92 +++++++++
 3 files changed

// File: rtl/ofifo_pkg.sv
// Shared defaults and helpers for the output-side column aligner.
package ofifo_pkg;

    localparam int unsigned OFIFO_COL   = 8;
    localparam int unsigned OFIFO_BW    = 16;
    localparam int unsigned OFIFO_DEPTH = 64;

    // Pointer/count width: one extra bit so full and empty are distinguishable.
    function automatic int unsigned ofifo_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_lane.sv
// One lane of the aligner: a circular buffer with write/read pointers and count.
// With OFIFO_OVF_DETECT_EN defined, ovf_o pulses when a write is dropped on a full lane.
module ofifo_lane
    import ofifo_pkg::*;
#(
    parameter int unsigned bw    = OFIFO_BW,
    parameter int unsigned depth = OFIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_i,
    input  logic [bw-1:0] data_i,
    input  logic          pop_i,
    output logic [bw-1:0] head_o,
    output logic          empty_o,
    output logic          full_o
`ifdef OFIFO_OVF_DETECT_EN
    ,
    output logic          ovf_o
`endif
);

    localparam int unsigned PtrW = ofifo_ptr_w(depth);
    localparam int unsigned IdxW = PtrW - 1;

    logic [bw-1:0]   mem_q [depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] count_q, count_d;
    logic            wr_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == PtrW'(depth));
    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
    assign wr_en   = wr_i && !full_o;
    assign head_o  = mem_q[rd_ptr_q[IdxW-1:0]];

`ifdef OFIFO_OVF_DETECT_EN
    assign ovf_o = wr_i && full_o;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({wr_en, pop_i})
            2'b10:   count_d = count_q + PtrW'(1);
            2'b01:   count_d = count_q - PtrW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/ofifo_align.sv
// Output column aligner: per-lane FIFOs popped together once every lane holds data.
// Optional sticky per-lane overflow flags o_ovf when OFIFO_OVF_DETECT_EN is defined.
module ofifo_align
    import ofifo_pkg::*;
#(
    parameter int unsigned col   = OFIFO_COL,
    parameter int unsigned bw    = OFIFO_BW,
    parameter int unsigned depth = OFIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [col*bw-1:0] in,
    input  logic [col-1:0]    wr,
    input  logic              rd,
    output logic [col*bw-1:0] out,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_ready
`ifdef OFIFO_OVF_DETECT_EN
    ,
    output logic [col-1:0]    o_ovf
`endif
);

    logic [col-1:0]    lane_empty;
    logic [col-1:0]    lane_full;
    logic [col*bw-1:0] head_row;
    logic [col*bw-1:0] out_q, out_d;
    logic              pop;

`ifdef OFIFO_OVF_DETECT_EN
    logic [col-1:0]    lane_ovf;
    logic [col-1:0]    ovf_q, ovf_d;
`endif

    assign o_valid = ~|lane_empty;
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign pop     = rd && o_valid;

    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(
            .bw    (bw),
            .depth (depth)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_i    (wr[i]),
            .data_i  (in[bw*i +: bw]),
            .pop_i   (pop),
            .head_o  (head_row[bw*i +: bw]),
            .empty_o (lane_empty[i]),
            .full_o  (lane_full[i])
`ifdef OFIFO_OVF_DETECT_EN
            ,
            .ovf_o   (lane_ovf[i])
`endif
        );
    end

    always_comb begin
        out_d = out_q;
        if (pop) begin
            out_d = head_row;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

`ifdef OFIFO_OVF_DETECT_EN
    assign ovf_d = ovf_q | lane_ovf;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_ovf = ovf_q;
`endif

endmodule
